// File: rtl/tank_pkg.sv
// tank_pkg: direction codes, launcher states and playfield limits
// shared by the tank fire-control path and the Missile block.
package tank_pkg;

    localparam int FIELD_MAX_C = 256;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        LEFT  = 2'b01,
        DOWN  = 2'b10,
        RIGHT = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        READY,
        LAUNCH,
        WAIT_ACK,
        IN_FLIGHT,
        COOLDOWN
    } state_t;

    // Off-field coordinates are pinned to the nearest legal pixel.
    function automatic logic [9:0] sat_coord(input int v, input int fmax);
        if (v < 0) return '0;
        if (v >= fmax) return 10'(fmax - 1);
        return 10'(v);
    endfunction

endpackage

// File: rtl/missile_launcher_if.sv
// missile_launcher_if: fire request, tank pose, Missile feedback and
// launch outputs. master = launcher, slave = tank/Missile side.
interface missile_launcher_if;

    logic       fire_key;
    logic       tank_alive;
    logic [9:0] TankX;
    logic [9:0] TankY;
    logic [1:0] TankDir;
    logic       MissileDisplay;
    logic       Missile_on;
    logic [9:0] Xstart;
    logic [9:0] Ystart;
    logic [1:0] TankType;
    logic       launcher_busy;
    logic [7:0] shots_fired;

    modport master (
        input  fire_key, tank_alive, TankX, TankY, TankDir,
        input  MissileDisplay,
        output Missile_on, Xstart, Ystart, TankType,
        output launcher_busy, shots_fired
    );

    modport slave (
        output fire_key, tank_alive, TankX, TankY, TankDir,
        output MissileDisplay,
        input  Missile_on, Xstart, Ystart, TankType,
        input  launcher_busy, shots_fired
    );

endinterface

// File: rtl/muzzle_calc.sv
// muzzle_calc: tank pose -> missile start pixel just outside the
// sprite on the facing side, saturated to the playfield.
module muzzle_calc
    import tank_pkg::*;
#(
    parameter int TANK_SIZE = 16,
    parameter int FIELD_MAX = FIELD_MAX_C
) (
    input  logic [9:0] tank_x_i,
    input  logic [9:0] tank_y_i,
    input  dir_t       dir_i,
    output logic [9:0] x_o,
    output logic [9:0] y_o
);

    localparam int H = TANK_SIZE / 2;

    int dx;
    int dy;

    always_comb begin
        dx = 0;
        dy = 0;
        unique case (dir_i)
            UP:    begin dx = H - 1;     dy = -1;        end
            DOWN:  begin dx = H - 1;     dy = TANK_SIZE; end
            LEFT:  begin dx = -1;        dy = H - 1;     end
            RIGHT: begin dx = TANK_SIZE; dy = H - 1;     end
            default: ;
        endcase
        x_o = sat_coord(int'(tank_x_i) + dx, FIELD_MAX);
        y_o = sat_coord(int'(tank_y_i) + dy, FIELD_MAX);
    end

endmodule

// File: rtl/missile_launcher.sv
// missile_launcher: fire key -> one-frame Missile_on, flight tracking
// and cooldown. Define FIRE_BUFFER_EN to keep one press from COOLDOWN.
module missile_launcher
    import tank_pkg::*;
#(
    parameter int TANK_SIZE       = 16,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int ACK_TIMEOUT     = 4,
    parameter int FIELD_MAX       = FIELD_MAX_C
) (
    input  logic              frame_clk,
    input  logic              Reset,
    missile_launcher_if.master bus
);

    localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(COOLDOWN_FRAMES);
    localparam logic [CNT_W-1:0] ACK_LIM = CNT_W'(ACK_TIMEOUT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fire_prev_q;
    logic [9:0]       xs_q, ys_q;
    dir_t             ty_q;
    logic [7:0]       shots_q;
    logic [9:0]       mx, my;
    logic             fire_edge;
    logic             go;
    logic             latch;
    logic             pend_q;

    muzzle_calc #(
        .TANK_SIZE (TANK_SIZE),
        .FIELD_MAX (FIELD_MAX)
    ) u_muzzle (
        .tank_x_i (bus.TankX),
        .tank_y_i (bus.TankY),
        .dir_i    (dir_t'(bus.TankDir)),
        .x_o      (mx),
        .y_o      (my)
    );

    assign fire_edge = bus.fire_key & ~fire_prev_q;
    assign go        = (fire_edge | pend_q) & bus.tank_alive;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        unique case (state_q)
            READY: begin
                if (go) begin
                    state_d = LAUNCH;
                    latch   = 1'b1;
                end
            end
            LAUNCH: begin
                state_d = WAIT_ACK;
                cnt_d   = '0;
            end
            WAIT_ACK: begin
                if (bus.MissileDisplay) begin
                    state_d = IN_FLIGHT;
                end else if (cnt_q + 1'b1 >= ACK_LIM) begin
                    state_d = COOLDOWN;
                    cnt_d   = CD_LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IN_FLIGHT: begin
                if (!bus.MissileDisplay) begin
                    state_d = COOLDOWN;
                    cnt_d   = CD_LOAD;
                end
            end
            COOLDOWN: begin
                if (cnt_q == '0) state_d = READY;
                else cnt_d = cnt_q - 1'b1;
            end
            default: state_d = READY;
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= READY;
            cnt_q       <= '0;
            fire_prev_q <= 1'b1;
            xs_q        <= '0;
            ys_q        <= '0;
            ty_q        <= UP;
            shots_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fire_prev_q <= bus.fire_key;
            if (latch) begin
                xs_q <= mx;
                ys_q <= my;
                ty_q <= dir_t'(bus.TankDir);
            end
            if (state_q == LAUNCH) shots_q <= shots_q + 8'd1;
        end
    end

`ifdef FIRE_BUFFER_EN
    logic pend_d;

    // READY consumes the flag on entry whether or not it launches.
    always_comb begin
        pend_d = pend_q;
        if (state_q == READY) pend_d = 1'b0;
        else if (state_q == COOLDOWN && fire_edge) pend_d = 1'b1;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) pend_q <= 1'b0;
        else pend_q <= pend_d;
    end
`else
    assign pend_q = 1'b0;
`endif

    assign bus.Missile_on    = (state_q == LAUNCH);
    assign bus.Xstart        = xs_q;
    assign bus.Ystart        = ys_q;
    assign bus.TankType      = ty_q;
    assign bus.launcher_busy = (state_q != READY);
    assign bus.shots_fired   = shots_q;

endmodule

// File: tb/tb_missile_launcher.sv
// tb_missile_launcher: directed and randomized fire sequences against
// a frame-count model of launch, flight, timeout and cooldown.
module tb_missile_launcher;
    import tank_pkg::*;

    localparam int TS = 16;
    localparam int CD = 8;
    localparam int AT = 4;
    localparam int FM = 256;
    // COOLDOWN counts N down to 0 inclusive.
    localparam int CD_FRAMES = CD + 1;
`ifdef FIRE_BUFFER_EN
    localparam int BUF = 1;
`else
    localparam int BUF = 0;
`endif

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;

    missile_launcher_if bus ();

    missile_launcher #(
        .TANK_SIZE       (TS),
        .COOLDOWN_FRAMES (CD),
        .ACK_TIMEOUT     (AT),
        .FIELD_MAX       (FM)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    int n_pass = 0;
    int n_total = 0;
    int shots_exp = 0;
    int xs_exp = 0;
    int ys_exp = 0;
    int ty_exp = 0;

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : ((v >= FM) ? FM - 1 : v);
    endfunction

    task automatic model_launch(input int x, input int y, input int d);
        int cx;
        int cy;
        cx = x + TS / 2 - 1;
        cy = y + TS / 2 - 1;
        case (d)
            0: begin xs_exp = clamp(cx); ys_exp = clamp(y - 1); end
            1: begin xs_exp = clamp(x - 1); ys_exp = clamp(cy); end
            2: begin xs_exp = clamp(cx); ys_exp = clamp(y + TS); end
            default: begin xs_exp = clamp(x + TS); ys_exp = clamp(cy); end
        endcase
        ty_exp = d;
        shots_exp++;
    endtask

    task automatic tick;
        @(posedge frame_clk);
        #1;
    endtask

    task automatic press(input int x, input int y, input int d, input bit hold);
        bus.TankX    = 10'(x);
        bus.TankY    = 10'(y);
        bus.TankDir  = 2'(d);
        bus.fire_key = 1'b1;
        tick();
        if (!hold) bus.fire_key = 1'b0;
    endtask

    task automatic drain(input int budget, output int frames, output int pulses);
        frames = 0;
        pulses = 0;
        while (bus.launcher_busy === 1'b1 && frames < budget) begin
            tick();
            frames++;
            if (bus.Missile_on === 1'b1) pulses++;
        end
        if (bus.launcher_busy !== 1'b0) frames = -1;
    endtask

    task automatic test_reset;
        int p;
        int b;
        bus.fire_key = 1'b1;
        bus.tank_alive = 1'b1;
        bus.MissileDisplay = 1'b0;
        bus.TankX = '0;
        bus.TankY = '0;
        bus.TankDir = '0;
        Reset = 1'b1;
        repeat (2) tick();
        n_total++; if (bus.Missile_on !== 1'b0) $display("FAIL rst_on: got %b want 0", bus.Missile_on); else n_pass++;
        n_total++; if (bus.launcher_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.launcher_busy); else n_pass++;
        n_total++; if (bus.shots_fired !== 8'd0) $display("FAIL rst_shots: got %0d want 0", bus.shots_fired); else n_pass++;
        n_total++; if (bus.Xstart !== 10'd0) $display("FAIL rst_x: got %0d want 0", bus.Xstart); else n_pass++;
        n_total++; if (bus.Ystart !== 10'd0) $display("FAIL rst_y: got %0d want 0", bus.Ystart); else n_pass++;
        n_total++; if (bus.TankType !== 2'd0) $display("FAIL rst_type: got %0d want 0", bus.TankType); else n_pass++;
        Reset = 1'b0;
        p = 0;
        b = 0;
        repeat (4) begin
            tick();
            p += int'(bus.Missile_on);
            b += int'(bus.launcher_busy);
        end
        n_total++; if (p != 0) $display("FAIL held_key_pulses: got %0d want 0", p); else n_pass++;
        n_total++; if (b != 0) $display("FAIL held_key_busy: got %0d want 0", b); else n_pass++;
        bus.fire_key = 1'b0;
        tick();
    endtask

    task automatic test_first_shot_cooldown;
        int f;
        int p;
        int early;
        press(100, 100, 3, 1'b0);
        model_launch(100, 100, 3);
        n_total++; if (bus.Missile_on !== 1'b1) $display("FAIL shot_on: got %b want 1", bus.Missile_on); else n_pass++;
        n_total++; if (int'(bus.Xstart) != 116) $display("FAIL shot_x: got %0d want 116", bus.Xstart); else n_pass++;
        n_total++; if (int'(bus.Ystart) != 107) $display("FAIL shot_y: got %0d want 107", bus.Ystart); else n_pass++;
        n_total++; if (int'(bus.TankType) != ty_exp) $display("FAIL shot_type: got %0d want %0d", bus.TankType, ty_exp); else n_pass++;
        tick();
        n_total++; if (bus.Missile_on !== 1'b0) $display("FAIL shot_one_frame: got %b want 0", bus.Missile_on); else n_pass++;
        n_total++; if (int'(bus.shots_fired) != shots_exp) $display("FAIL shot_count: got %0d want %0d", bus.shots_fired, shots_exp); else n_pass++;
        bus.MissileDisplay = 1'b1;
        repeat (18) tick();
        n_total++; if (bus.launcher_busy !== 1'b1) $display("FAIL flight_busy: got %b want 1", bus.launcher_busy); else n_pass++;
        bus.MissileDisplay = 1'b0;
        early = 0;
        tick(); early += int'(bus.Missile_on);
        tick(); early += int'(bus.Missile_on);
        bus.fire_key = 1'b1;
        tick(); early += int'(bus.Missile_on);
        bus.fire_key = 1'b0;
        drain(40, f, p);
        n_total++; if (f + 3 != 1 + CD_FRAMES) $display("FAIL cooldown_len: got %0d want %0d", f + 3, 1 + CD_FRAMES); else n_pass++;
        n_total++; if (p + early != 0) $display("FAIL cooldown_press: got %0d pulses want 0", p + early); else n_pass++;
        tick();
        n_total++; if (int'(bus.Missile_on) != BUF) $display("FAIL buffered_shot: got %b want %0d", bus.Missile_on, BUF); else n_pass++;
        if (bus.Missile_on === 1'b1) model_launch(100, 100, 3);
        n_total++; if (int'(bus.Xstart) != xs_exp) $display("FAIL buffered_x: got %0d want %0d", bus.Xstart, xs_exp); else n_pass++;
        drain(40, f, p);
        n_total++; if (f != BUF * (1 + AT + CD_FRAMES)) $display("FAIL buffered_drain: got %0d want %0d", f, BUF * (1 + AT + CD_FRAMES)); else n_pass++;
    endtask

    task automatic test_timeout_held;
        int f;
        int p;
        press(60, 40, 2, 1'b1);
        model_launch(60, 40, 2);
        n_total++; if (bus.Missile_on !== 1'b1) $display("FAIL to_on: got %b want 1", bus.Missile_on); else n_pass++;
        n_total++; if (int'(bus.Ystart) != ys_exp) $display("FAIL to_y: got %0d want %0d", bus.Ystart, ys_exp); else n_pass++;
        drain(40, f, p);
        n_total++; if (f != 1 + AT + CD_FRAMES) $display("FAIL to_len: got %0d want %0d", f, 1 + AT + CD_FRAMES); else n_pass++;
        n_total++; if (p != 0) $display("FAIL to_extra: got %0d pulses want 0", p); else n_pass++;
        p = 0;
        repeat (3) begin
            tick();
            p += int'(bus.Missile_on);
        end
        n_total++; if (p != 0) $display("FAIL held_reentry: got %0d pulses want 0", p); else n_pass++;
        bus.fire_key = 1'b0;
        tick();
    endtask

    task automatic test_saturation;
        int tx[3] = '{50, 250, 0};
        int tyy[3] = '{0, 100, 30};
        int td[3] = '{0, 3, 1};
        int f;
        int p;
        for (int i = 0; i < 3; i++) begin
            press(tx[i], tyy[i], td[i], 1'b0);
            model_launch(tx[i], tyy[i], td[i]);
            n_total++; if (bus.Missile_on !== 1'b1) $display("FAIL sat_on[%0d]: got %b want 1", i, bus.Missile_on); else n_pass++;
            n_total++; if (int'(bus.Xstart) != xs_exp) $display("FAIL sat_x[%0d]: got %0d want %0d", i, bus.Xstart, xs_exp); else n_pass++;
            n_total++; if (int'(bus.Ystart) != ys_exp) $display("FAIL sat_y[%0d]: got %0d want %0d", i, bus.Ystart, ys_exp); else n_pass++;
            drain(40, f, p);
            n_total++; if (f != 1 + AT + CD_FRAMES) $display("FAIL sat_drain[%0d]: got %0d want %0d", i, f, 1 + AT + CD_FRAMES); else n_pass++;
        end
    endtask

    task automatic test_dead_tank;
        bus.tank_alive = 1'b0;
        press(200, 200, 1, 1'b0);
        n_total++; if (bus.Missile_on !== 1'b0) $display("FAIL dead_on: got %b want 0", bus.Missile_on); else n_pass++;
        n_total++; if (bus.launcher_busy !== 1'b0) $display("FAIL dead_busy: got %b want 0", bus.launcher_busy); else n_pass++;
        n_total++; if (int'(bus.Xstart) != xs_exp) $display("FAIL dead_x_hold: got %0d want %0d", bus.Xstart, xs_exp); else n_pass++;
        bus.tank_alive = 1'b1;
        tick();
    endtask

    task automatic test_random;
        int x, y, d, ack, fly, f, p, want;
        bit alive;
        for (int it = 0; it < 12; it++) begin
            x = int'($urandom_range(0, 1023));
            y = int'($urandom_range(0, 1023));
            d = int'($urandom_range(0, 3));
            alive = ($urandom_range(0, 3) != 0);
            ack = int'($urandom_range(0, 1));
            bus.tank_alive = alive;
            press(x, y, d, 1'b0);
            if (alive) model_launch(x, y, d);
            n_total++; if (bus.Missile_on !== alive) $display("FAIL rnd_on[%0d]: got %b want %b", it, bus.Missile_on, alive); else n_pass++;
            n_total++; if (int'(bus.Xstart) != xs_exp || int'(bus.Ystart) != ys_exp || int'(bus.TankType) != ty_exp)
                $display("FAIL rnd_pose[%0d]: got %0d,%0d,%0d want %0d,%0d,%0d", it, bus.Xstart, bus.Ystart, bus.TankType, xs_exp, ys_exp, ty_exp);
            else n_pass++;
            bus.tank_alive = 1'b1;
            tick();
            if (ack != 0) begin
                bus.MissileDisplay = 1'b1;
                fly = int'($urandom_range(1, 8));
                repeat (fly) tick();
                bus.MissileDisplay = 1'b0;
                want = alive ? 1 + CD_FRAMES : 0;
            end else begin
                want = alive ? AT + CD_FRAMES : 0;
            end
            drain(60, f, p);
            n_total++; if (f != want || p != 0) $display("FAIL rnd_flight[%0d]: got %0d frames %0d pulses want %0d frames 0 pulses", it, f, p, want); else n_pass++;
            n_total++; if (int'(bus.shots_fired) != (shots_exp % 256) || int'(bus.Xstart) != xs_exp)
                $display("FAIL rnd_after[%0d]: got shots %0d x %0d want %0d x %0d", it, bus.shots_fired, bus.Xstart, shots_exp % 256, xs_exp);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midflight;
        int f;
        int p;
        press(120, 80, 2, 1'b0);
        model_launch(120, 80, 2);
        tick();
        bus.MissileDisplay = 1'b1;
        repeat (3) tick();
        n_total++; if (bus.launcher_busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", bus.launcher_busy); else n_pass++;
        #2 Reset = 1'b1;
        #1;
        shots_exp = 0;
        xs_exp = 0;
        n_total++; if (bus.launcher_busy !== 1'b0) $display("FAIL async_busy: got %b want 0", bus.launcher_busy); else n_pass++;
        n_total++; if (int'(bus.shots_fired) != shots_exp) $display("FAIL async_shots: got %0d want 0", bus.shots_fired); else n_pass++;
        n_total++; if (int'(bus.Xstart) != xs_exp) $display("FAIL async_x: got %0d want 0", bus.Xstart); else n_pass++;
        n_total++; if (bus.Missile_on !== 1'b0) $display("FAIL async_on: got %b want 0", bus.Missile_on); else n_pass++;
        bus.MissileDisplay = 1'b0;
        #1 Reset = 1'b0;
        tick();
        press(10, 10, 0, 1'b0);
        model_launch(10, 10, 0);
        tick();
        n_total++; if (int'(bus.shots_fired) != shots_exp) $display("FAIL post_rst_shots: got %0d want %0d", bus.shots_fired, shots_exp); else n_pass++;
        drain(40, f, p);
        n_total++; if (f != AT + CD_FRAMES) $display("FAIL post_rst_drain: got %0d want %0d", f, AT + CD_FRAMES); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_shot_cooldown();
        test_timeout_held();
        test_saturation();
        test_dead_tank();
        test_random();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
